// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, step encoding and control-word layout for the Mini SRC control unit.
// Pure declarations: no logic, no timing.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3,
    ST_T4, ST_T5, ST_T6, ST_T7, ST_T8, ST_T9,
    ST_HALT
  } step_t;

  typedef enum logic [3:0] {
    CL_ALU3, CL_ALUI, CL_ALU2, CL_MULDIV,
    CL_LDI, CL_LD, CL_ST, CL_BR,
    CL_JR, CL_JAL, CL_IN, CL_OUT,
    CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
  } iclass_t;

  typedef struct packed {
    logic       pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
    logic       pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic       gra, grb, grc, rin, rout, baout;
    logic       read, write;
    logic [4:0] alu;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Opcode to instruction class and execute-sequence length; purely combinational.
// A length of 0 means the decode step (T4) does nothing and the sequencer leaves immediately.
module control_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        iclass,
  output logic [2:0]     seq_len
);

  always_comb begin
    iclass  = CL_NOP;
    seq_len = 3'd0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        iclass = CL_ALU3;   seq_len = 3'd3;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        iclass = CL_ALUI;   seq_len = 3'd3;
      end
      OP_NEG, OP_NOT: begin
        iclass = CL_ALU2;   seq_len = 3'd2;
      end
      OP_MUL, OP_DIV: begin
        iclass = CL_MULDIV; seq_len = 3'd4;
      end
      OP_LDI:  begin iclass = CL_LDI;  seq_len = 3'd3; end
      OP_LD:   begin iclass = CL_LD;   seq_len = 3'd6; end
      OP_ST:   begin iclass = CL_ST;   seq_len = 3'd5; end
      OP_BR:   begin iclass = CL_BR;   seq_len = 3'd4; end
      OP_JR:   begin iclass = CL_JR;   seq_len = 3'd1; end
      OP_JAL:  begin iclass = CL_JAL;  seq_len = 3'd2; end
      OP_IN:   begin iclass = CL_IN;   seq_len = 3'd1; end
      OP_OUT:  begin iclass = CL_OUT;  seq_len = 3'd1; end
      OP_MFHI: begin iclass = CL_MFHI; seq_len = 3'd1; end
      OP_MFLO: begin iclass = CL_MFLO; seq_len = 3'd1; end
      OP_HALT: begin iclass = CL_HALT; seq_len = 3'd0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: one control step per clk, fetch then per-class execute sequence.
// Controls are decoded from the step register; stop only gates the T0 step (pause before fetch).
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  input  logic        stop,
  output logic        run,
  output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
  output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, Write,
  output logic [4:0]  alu_instruction_bits
);

  step_t          state;
  iclass_t        iclass;
  logic [2:0]     seq_len;
  logic [3:0]     exec_idx;
  logic           last_step;
  logic [OPW-1:0] opcode;
  ctrl_t          c;

  assign opcode    = IR_Data[31 -: OPW];
  assign exec_idx  = state - ST_T4;
  assign last_step = ({1'b0, seq_len} <= (exec_idx + 4'd1));

  control_decode #(.OPW(OPW)) u_decode (
    .opcode  (opcode),
    .iclass  (iclass),
    .seq_len (seq_len)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_RST;
    end else begin
      case (state)
        ST_RST:  state <= ST_T0;
        ST_T0:   if (!stop) state <= ST_T1;
        ST_T1:   state <= ST_T2;
        ST_T2:   state <= ST_T3;
        ST_T3:   state <= ST_T4;
        ST_HALT: state <= ST_HALT;
        default: begin
          if (iclass == CL_HALT) state <= ST_HALT;
          else if (last_step)    state <= ST_T0;
          else                   state <= step_t'(state + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state)
      ST_T0: if (!stop) begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      ST_T1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; end
      ST_T2: begin c.read = 1'b1; c.mdr_in = 1'b1; end
      ST_T3: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      ST_T4, ST_T5, ST_T6, ST_T7, ST_T8, ST_T9: begin
        case (iclass)
          CL_ALU3, CL_ALUI: case (exec_idx)
            4'd0: begin c.grb = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
            4'd1: begin
              if (iclass == CL_ALU3) begin c.grc = 1'b1; c.rout = 1'b1; end
              else                   c.c_out = 1'b1;
              c.z_in = 1'b1; c.alu = opcode;
            end
            4'd2: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            default: ;
          endcase
          CL_ALU2: case (exec_idx)
            4'd0: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
            4'd1: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            default: ;
          endcase
          CL_MULDIV: case (exec_idx)
            4'd0: begin c.gra = 1'b1; c.rout = 1'b1; c.y_in = 1'b1; end
            4'd1: begin c.grb = 1'b1; c.rout = 1'b1; c.z_in = 1'b1; c.alu = opcode; end
            4'd2: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
            4'd3: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
            default: ;
          endcase
          // ldi/ld/st share the base+offset address calculation in their first three steps
          CL_LDI, CL_LD, CL_ST: case (exec_idx)
            4'd0: begin c.grb = 1'b1; c.baout = 1'b1; c.y_in = 1'b1; end
            4'd1: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
            4'd2: begin
              c.zlow_out = 1'b1;
              if (iclass == CL_LDI) begin c.gra = 1'b1; c.rin = 1'b1; end
              else                  c.mar_in = 1'b1;
            end
            4'd3: begin
              if (iclass == CL_LD) c.read = 1'b1;
              else begin c.gra = 1'b1; c.rout = 1'b1; c.mdr_in = 1'b1; end
            end
            4'd4: begin
              if (iclass == CL_LD) begin c.read = 1'b1; c.mdr_in = 1'b1; end
              else                 c.write = 1'b1;
            end
            4'd5: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
            default: ;
          endcase
          CL_BR: case (exec_idx)
            4'd0: begin c.gra = 1'b1; c.rout = 1'b1; end
            4'd1: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            4'd2: begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu = ALU_ADD; end
            4'd3: if (CON_out) begin c.zlow_out = 1'b1; c.pc_in = 1'b1; end
            default: ;
          endcase
          CL_JR:  begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
          CL_JAL: case (exec_idx)
            4'd0: begin c.pc_out = 1'b1; c.grb = 1'b1; c.rin = 1'b1; end
            4'd1: begin c.gra = 1'b1; c.rout = 1'b1; c.pc_in = 1'b1; end
            default: ;
          endcase
          CL_IN:   begin c.inport_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CL_OUT:  begin c.gra = 1'b1; c.rout = 1'b1; c.outport_in = 1'b1; end
          CL_MFHI: begin c.hi_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          CL_MFLO: begin c.lo_out = 1'b1; c.gra = 1'b1; c.rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run = (state != ST_RST) && (state != ST_HALT) && !((state == ST_T0) && stop);

  assign PC_in      = c.pc_in;
  assign IR_in      = c.ir_in;
  assign Y_in       = c.y_in;
  assign Z_in       = c.z_in;
  assign HI_in      = c.hi_in;
  assign LO_in      = c.lo_in;
  assign MAR_in     = c.mar_in;
  assign MDR_in     = c.mdr_in;
  assign OutPort_in = c.outport_in;
  assign IncPC      = c.inc_pc;
  assign PC_out     = c.pc_out;
  assign Zhigh_out  = c.zhigh_out;
  assign Zlow_out   = c.zlow_out;
  assign HI_out     = c.hi_out;
  assign LO_out     = c.lo_out;
  assign MDR_out    = c.mdr_out;
  assign InPort_out = c.inport_out;
  assign C_out      = c.c_out;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.rin;
  assign Rout       = c.rout;
  assign BAout      = c.baout;
  assign Read       = c.read;
  assign Write      = c.write;
  assign alu_instruction_bits = c.alu;

endmodule
